ex_div_controller: RTL

Multi-cycle sequencer for RV32M division/remainder in the EX stage. Accepts a DIV/DIVU/REM/REMU request from EX, stalls the front of the pipeline while an iterative restoring divider runs, then presents the 32-bit result together with the `zero_division` / `overflow_signed_div` flags for capture into the EX/MEM pipeline register. Owns the divider datapath registers and the stall/flush interaction with the hazard logic.

---
 rtl/riscv_div_pkg.sv | 29 ++
 rtl/div_iter_step.sv | 29 ++
 rtl/ex_div_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the RV32M divide sequencer: FSM states,
// op encodings and the special-case result values.
package riscv_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One combinational restoring-division step on magnitudes: shift {rem,quo}
// left by one, trial-subtract the divisor, keep the difference if non-negative.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor holds between steps, so one extra bit is enough for the trial.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[XLEN]) begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_controller.sv
// EX-stage RV32M DIV/DIVU/REM/REMU sequencer around an iterative restoring divider.
// Optional DIV_EARLY_OUT_EN: skip iteration when |divisor| > |dividend|.
module ex_div_controller
  import riscv_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_division_o,
  output logic            overflow_signed_div_o
);

  div_state_e      state_q, state_d;
  logic            rem_sel_q, rem_sel_d;
  logic            neg_q, neg_d;
  logic            zd_q, zd_d;
  logic            ov_q, ov_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            req_signed, req_rem, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, step_rem, step_quo;

  assign req_signed = op_is_signed(op_i);
  assign req_rem    = op_is_rem(op_i);
  assign a_mag      = (req_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign b_mag      = (req_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
  assign div_zero   = (divisor_i == '0);
  assign div_ovf    = req_signed && (dividend_i == SIGNED_MIN) && (divisor_i == '1);

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    neg_d     = neg_q;
    zd_d      = zd_q;
    ov_d      = ov_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    // A flush kills whatever is in flight and blocks a same-cycle request.
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_sel_d = req_rem;
            neg_d     = req_signed && (req_rem ? dividend_i[XLEN-1]
                                               : (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]));
            zd_d      = 1'b0;
            ov_d      = 1'b0;
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            cnt_d     = CNT_W'(DIV_ITERS);
            if (div_zero) begin
              state_d  = DONE;
              zd_d     = 1'b1;
              result_d = req_rem ? dividend_i : DIV_ZERO_QUOT;
            end else if (div_ovf) begin
              state_d  = DONE;
              ov_d     = 1'b1;
              result_d = req_rem ? '0 : SIGNED_MIN;
`ifdef DIV_EARLY_OUT_EN
            end else if (b_mag > a_mag) begin
              state_d = FIX;
              quo_d   = '0;
              rem_d   = a_mag;
              cnt_d   = '0;
`endif
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
        FIX: begin
          if (rem_sel_q) result_d = neg_q ? -rem_q : rem_q;
          else           result_d = neg_q ? -quo_q : quo_q;
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      zd_q      <= 1'b0;
      ov_q      <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      neg_q     <= neg_d;
      zd_q      <= zd_d;
      ov_q      <= ov_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  // Combinational so the requesting instruction is held from its first EX cycle.
  assign stall_o = ((state_q == IDLE) && start_i && !flush_i)
                 || (state_q == CALC) || (state_q == FIX);
  assign done_o                = (state_q == DONE);
  assign result_o              = result_q;
  assign zero_division_o       = zd_q;
  assign overflow_signed_div_o = ov_q;

endmodule
